// File: rtl/mux_scan_ctrl_if.sv
// Interface between the scan controller and the rest of the design. It carries the control
// inputs, the y bit returned by the downstream 4:1 mux, and the scan outputs.
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       abort;
  logic       y;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] sample;

  modport master (output start, cont, abort, y, input sel, busy, done, sample);
  modport slave  (input start, cont, abort, y, output sel, busy, done, sample);
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through channels 0..3, holding each for DWELL cycles before capturing y.
// Each scan takes 4*DWELL cycles to done. No backpressure; start is ignored while busy.
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state, state_nxt;
  logic [1:0] sel, sel_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] shadow, shadow_nxt;
  logic [3:0] sample, sample_nxt;
  logic       done, done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= 2'd0;
      cnt    <= 8'd0;
      shadow <= 4'd0;
      sample <= 4'd0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
      sample <= sample_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    sample_nxt = sample;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        sel_nxt = 2'd0;
        cnt_nxt = 8'd0;
        if (bus.start && !bus.abort) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          // Abort wins over capture: the partial result is dropped and no done pulse is produced.
          state_nxt  = IDLE;
          sel_nxt    = 2'd0;
          cnt_nxt    = 8'd0;
          shadow_nxt = 4'd0;
        end else if (cnt == LAST) begin
          cnt_nxt         = 8'd0;
          shadow_nxt[sel] = bus.y;
          if (sel == 2'd3) begin
            sample_nxt = shadow_nxt;
            shadow_nxt = 4'd0;
            done_nxt   = 1'b1;
            sel_nxt    = 2'd0;
            if (!bus.cont) begin
              state_nxt = IDLE;
            end
          end else begin
            sel_nxt = sel + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sel    = sel;
  assign bus.busy   = (state == SCAN);
  assign bus.done   = done;
  assign bus.sample = sample;

endmodule
